register_file: RTL and testbench

Y86-64 architectural register file and retirement tracker, fed by the writeback pipeline register. It commits the two writeback results (E and M ports) into fifteen 64-bit registers and serves two combinational read ports to decode. It also maintains the sticky processor status and a retired-instruction counter. It sits at the consumer end of the W stage and closes the loop back to decode.

---
 rtl/register_file_if.sv | 54 +++++
 rtl/register_file.sv | 121 ++++++++++++
 tb/tb_register_file.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Writeback-to-register-file bundle: W stage inputs,
// decode read ports, and the retirement/status outputs.
interface register_file_if #(
  parameter int CNT_W = 32
);
  logic [2:0]       W_stat;
  logic [3:0]       W_icode;
  logic [3:0]       W_dstE;
  logic [3:0]       W_dstM;
  logic [63:0]      W_valE;
  logic [63:0]      W_valM;
  logic             W_stall;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [63:0]      d_rvalA;
  logic [63:0]      d_rvalB;
  logic [2:0]       Stat;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output W_stat,
    output W_icode,
    output W_dstE,
    output W_dstM,
    output W_valE,
    output W_valM,
    output W_stall,
    output d_srcA,
    output d_srcB,
    input  d_rvalA,
    input  d_rvalB,
    input  Stat,
    input  halted,
    input  retired
  );

  modport slave (
    input  W_stat,
    input  W_icode,
    input  W_dstE,
    input  W_dstM,
    input  W_valE,
    input  W_valM,
    input  W_stall,
    input  d_srcA,
    input  d_srcB,
    output d_rvalA,
    output d_rvalB,
    output Stat,
    output halted,
    output retired
  );
endinterface

// File: rtl/register_file.sv
// Y86-64 register file: commits W-stage results, serves
// decode reads, tracks sticky status and retired count.
module register_file #(
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = 32
) (
  input logic       clk,
  input logic       reset,
  register_file_if.slave rf
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] I_NOP = 4'h1;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  logic [63:0]      regs [15];
  logic             w_fresh;
  logic             halted_q;
  logic [2:0]       stat_q;
  logic [CNT_W-1:0] ret_q;

  logic commit;
  logic is_aok;
  logic is_stop;
  logic wr_e;
  logic wr_m;
  logic stop;
  logic count;
  logic [63:0] rval_a;
  logic [63:0] rval_b;

  // W content is new only in the cycle after an unstalled edge
  assign commit = w_fresh & ~halted_q & ~reset;

  always_comb begin
    is_aok  = 1'b0;
    is_stop = 1'b0;
    unique case (1'b1)
      (rf.W_stat == S_AOK): is_aok  = 1'b1;
      (rf.W_stat == S_HLT),
      (rf.W_stat == S_ADR),
      (rf.W_stat == S_INS): is_stop = 1'b1;
      default: ;
    endcase
  end

  assign wr_e  = commit & is_aok
               & (rf.W_dstE != RNONE);
  assign wr_m  = commit & is_aok
               & (rf.W_dstM != RNONE);
  assign stop  = commit & is_stop;
  assign count = commit
               & (is_aok | (rf.W_stat == S_HLT))
               & (rf.W_icode != I_NOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= '0;
      end
      w_fresh  <= 1'b0;
      halted_q <= 1'b0;
      stat_q   <= S_AOK;
      ret_q    <= '0;
    end else begin
      w_fresh <= ~rf.W_stall;
      if (wr_e) begin
        regs[rf.W_dstE] <= rf.W_valE;
      end
      // M port written last so popq %rsp keeps valM
      if (wr_m) begin
        regs[rf.W_dstM] <= rf.W_valM;
      end
      if (stop) begin
        stat_q   <= rf.W_stat;
        halted_q <= 1'b1;
      end
      if (count) begin
        ret_q <= ret_q + 1'b1;
      end
    end
  end

  always_comb begin
    rval_a = '0;
    if (rf.d_srcA != RNONE) begin
      rval_a = regs[rf.d_srcA];
    end
    if (BYPASS && wr_e
        && rf.W_dstE == rf.d_srcA) begin
      rval_a = rf.W_valE;
    end
    if (BYPASS && wr_m
        && rf.W_dstM == rf.d_srcA) begin
      rval_a = rf.W_valM;
    end
  end

  always_comb begin
    rval_b = '0;
    if (rf.d_srcB != RNONE) begin
      rval_b = regs[rf.d_srcB];
    end
    if (BYPASS && wr_e
        && rf.W_dstE == rf.d_srcB) begin
      rval_b = rf.W_valE;
    end
    if (BYPASS && wr_m
        && rf.W_dstM == rf.d_srcB) begin
      rval_b = rf.W_valM;
    end
  end

  assign rf.d_rvalA = rval_a;
  assign rf.d_rvalB = rval_b;
  assign rf.Stat    = stat_q;
  assign rf.halted  = halted_q;
  assign rf.retired = ret_q;
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: two register_file instances (no bypass,
// 4-bit counter / bypass, 32-bit counter) on shared stimulus.
module tb_register_file;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset   = 1'b1;
  logic [2:0]  W_stat  = 3'd0;
  logic [3:0]  W_icode = 4'd0;
  logic [3:0]  W_dstE  = 4'hF;
  logic [3:0]  W_dstM  = 4'hF;
  logic [63:0] W_valE  = '0;
  logic [63:0] W_valM  = '0;
  logic        W_stall = 1'b0;
  logic [3:0]  d_srcA  = 4'd0;
  logic [3:0]  d_srcB  = 4'd0;

  register_file_if #(.CNT_W(4))  rf0 ();
  register_file_if #(.CNT_W(32)) rf1 ();

  assign rf0.W_stat  = W_stat;
  assign rf0.W_icode = W_icode;
  assign rf0.W_dstE  = W_dstE;
  assign rf0.W_dstM  = W_dstM;
  assign rf0.W_valE  = W_valE;
  assign rf0.W_valM  = W_valM;
  assign rf0.W_stall = W_stall;
  assign rf0.d_srcA  = d_srcA;
  assign rf0.d_srcB  = d_srcB;
  assign rf1.W_stat  = W_stat;
  assign rf1.W_icode = W_icode;
  assign rf1.W_dstE  = W_dstE;
  assign rf1.W_dstM  = W_dstM;
  assign rf1.W_valE  = W_valE;
  assign rf1.W_valM  = W_valM;
  assign rf1.W_stall = W_stall;
  assign rf1.d_srcA  = d_srcA;
  assign rf1.d_srcB  = d_srcB;

  register_file #(.BYPASS(1'b0), .CNT_W(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .rf    (rf0.slave)
  );

  register_file #(.BYPASS(1'b1), .CNT_W(32)) dut1 (
    .clk   (clk),
    .reset (reset),
    .rf    (rf1.slave)
  );

  typedef struct {
    logic [63:0] a0, b0, a1, b1;
    logic [2:0]  stat;
    logic        halted;
    logic [3:0]  r0;
    logic [31:0] r1;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   pushed = 0;
  int   done   = 0;

  // Architectural model: plain array plus status fields
  logic [63:0] m_r [15];
  logic [2:0]  m_stat  = 3'd1;
  logic        m_halt  = 1'b0;
  logic [3:0]  m_ret0  = 4'd0;
  logic [31:0] m_ret1  = 32'd0;
  logic        m_fresh = 1'b0;
  logic        prev_stall = 1'b0;

  initial begin
    for (int i = 0; i < 15; i++) m_r[i] = '0;
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [63:0] model_rd(
    input logic [3:0] id, input bit byp, input bit wr);
    logic [63:0] v;
    if (id == 4'hF) return 64'd0;
    v = m_r[id];
    if (byp && wr) begin
      if (W_dstM == id) v = W_valM;
      else if (W_dstE == id) v = W_valE;
    end
    return v;
  endfunction

  task automatic cyc(input logic rst, input logic st,
                     input logic [2:0] s, input logic [3:0] ic,
                     input logic [3:0] de, input logic [3:0] dm,
                     input logic [63:0] ve, input logic [63:0] vm,
                     input logic [3:0] sa, input logic [3:0] sb);
    exp_t e;
    bit   com;
    bit   wr;
    @(negedge clk);
    reset = rst; W_stall = st; W_stat = s; W_icode = ic;
    W_dstE = de; W_dstM = dm; W_valE = ve; W_valM = vm;
    d_srcA = sa; d_srcB = sb;
    prev_stall = st;
    com  = !rst && m_fresh && !m_halt;
    wr   = com && s == 3'd1;
    e.a0 = model_rd(sa, 1'b0, wr);
    e.b0 = model_rd(sb, 1'b0, wr);
    e.a1 = model_rd(sa, 1'b1, wr);
    e.b1 = model_rd(sb, 1'b1, wr);
    if (rst) begin
      for (int i = 0; i < 15; i++) m_r[i] = '0;
      m_stat = 3'd1; m_halt = 1'b0;
      m_ret0 = '0; m_ret1 = '0; m_fresh = 1'b0;
    end else begin
      if (wr) begin
        if (de != 4'hF) m_r[de] = ve;
        if (dm != 4'hF) m_r[dm] = vm;
      end
      if (com && s >= 3'd2 && s <= 3'd4) begin
        m_stat = s; m_halt = 1'b1;
      end
      if (com && (s == 3'd1 || s == 3'd2) && ic != 4'd1) begin
        m_ret0 = m_ret0 + 4'd1;
        m_ret1 = m_ret1 + 32'd1;
      end
      m_fresh = !st;
    end
    e.stat = m_stat; e.halted = m_halt;
    e.r0 = m_ret0; e.r1 = m_ret1;
    q.push_back(e);
    pushed++;
  endtask

  // Monitor: reads just after inputs settle, state after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("rvalA_nobyp", rf0.d_rvalA, e.a0);
        check("rvalB_nobyp", rf0.d_rvalB, e.b0);
        check("rvalA_byp", rf1.d_rvalA, e.a1);
        check("rvalB_byp", rf1.d_rvalB, e.b1);
        @(posedge clk);
        #1;
        check("stat0", {61'd0, rf0.Stat}, {61'd0, e.stat});
        check("stat1", {61'd0, rf1.Stat}, {61'd0, e.stat});
        check("halted0", {63'd0, rf0.halted}, {63'd0, e.halted});
        check("halted1", {63'd0, rf1.halted}, {63'd0, e.halted});
        check("retired4", {60'd0, rf0.retired}, {60'd0, e.r0});
        check("retired32", {32'd0, rf1.retired}, {32'd0, e.r1});
        done++;
      end
    end
  end

  task automatic aok(input logic [3:0] de, input logic [63:0] ve,
                     input logic [3:0] sa, input logic [3:0] sb);
    cyc(0, 0, 3'd1, 4'd3, de, 4'hF, ve, 64'd0, sa, sb);
  endtask

  logic [2:0]  r_s;
  logic [3:0]  r_ic, r_de, r_dm;
  logic [63:0] r_ve, r_vm;
  int          halt_wait;

  initial begin
    // First commit, and first-cycle-after-reset blocking
    cyc(1, 0, 3'd0, 4'd0, 4'hF, 4'hF, 0, 0, 0, 15);
    aok(4'd0, 64'h10, 4'd0, 4'd15);
    aok(4'd0, 64'h10, 4'd0, 4'd15);
    cyc(0, 0, 3'd0, 4'd0, 4'hF, 4'hF, 0, 0, 0, 15);
    // popq %rsp style conflict
    cyc(0, 0, 3'd1, 4'hB, 4'd4, 4'd4, 64'h8, 64'h99, 4, 0);
    cyc(0, 0, 3'd0, 4'd0, 4'hF, 4'hF, 0, 0, 4, 0);
    // Address fault freezes state
    cyc(0, 0, 3'd3, 4'd5, 4'hF, 4'd3, 0, 64'hDEAD, 3, 5);
    for (int i = 0; i < 4; i++) aok(4'd5, 64'h77, 4'd3, 4'd5);
    // Halt held by stall
    cyc(1, 0, 3'd0, 4'd0, 4'hF, 4'hF, 0, 0, 0, 0);
    cyc(0, 0, 3'd0, 4'd0, 4'hF, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      cyc(0, i != 0, 3'd2, 4'd0, 4'hF, 4'hF, 0, 0, 0, 0);
    // Same-cycle read of a committing register
    cyc(1, 0, 3'd0, 4'd0, 4'hF, 4'hF, 0, 0, 7, 7);
    aok(4'd7, 64'h55, 4'd0, 4'd7);
    aok(4'd7, 64'h55, 4'd0, 4'd7);
    aok(4'hF, 64'h0, 4'd0, 4'd7);
    // Counter wrap on the 4-bit instance, then reset mid-stream
    for (int i = 0; i < 18; i++)
      aok(4'(i % 15), 64'(i + 100), 4'(i % 15), 4'd6);
    cyc(1, 0, 3'd1, 4'd3, 4'd2, 4'd6, 1, 2, 2, 6);
    cyc(0, 0, 3'd1, 4'd3, 4'd2, 4'd6, 1, 2, 2, 6);
    // Randomised stream
    halt_wait = 0;
    r_s = 3'd0; r_ic = 4'd0; r_de = 4'hF; r_dm = 4'hF;
    r_ve = '0; r_vm = '0;
    for (int n = 0; n < 3000; n++) begin
      logic rst;
      int   p;
      rst = ($urandom_range(0, 199) == 0);
      if (m_halt) begin
        halt_wait++;
        if (halt_wait > int'($urandom_range(2, 10))) rst = 1'b1;
      end
      if (rst) halt_wait = 0;
      if (!prev_stall || rst) begin
        p = int'($urandom_range(0, 99));
        if (p < 95) r_s = 3'd1;
        else if (p < 97) r_s = 3'd0;
        else r_s = 3'(p - 95);
        r_ic = 4'($urandom_range(0, 11));
        r_de = 4'($urandom_range(0, 15));
        r_dm = ($urandom_range(0, 3) == 0) ? r_de
             : 4'($urandom_range(0, 15));
        r_ve = {$urandom, $urandom};
        r_vm = {$urandom, $urandom};
      end
      cyc(rst, $urandom_range(0, 3) == 0, r_s, r_ic,
          r_de, r_dm, r_ve, r_vm,
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    for (int t = 0; t < 20 && done < pushed; t++) @(posedge clk);
    #3;
    if (done < pushed) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d want %0d", done, pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
